combiner: RTL
=============

// Module: combiner
// PURPOSE
//  Joins two independent valid/ready streams (AM0, AM1) into one concatenated
//  output stream (BM) carrying {data1, data0}. It is the converging end of the
//  broadcaster split: it re-synchronises two streams that were split and then
//  processed with different latencies. Each input has its own holding buffer,
//  so skew between the inputs is absorbed. A registered output stage drives BM.
// PARAMETERS
//  WIDTH0  32     width of stream 0 data (low part of oData_BM)
//  WIDTH1  32     width of stream 1 data (high part of oData_BM)
//  BURST   "yes"  "yes": 2-entry input buffers, 1 word/cycle; any other value: 1-entry, 1 word/2 cycles
// PORTS
//  iCLK        in   1              clock, all logic on rising edge
//  iRST        in   1              synchronous reset, active-high
//  iValid_AM0  in   1              stream 0 valid
//  oReady_AM0  out  1              stream 0 ready (registered)
//  iData_AM0   in   WIDTH0         stream 0 data
//  iValid_AM1  in   1              stream 1 valid
//  oReady_AM1  out  1              stream 1 ready (registered)
//  iData_AM1   in   WIDTH1         stream 1 data
//  oValid_BM   out  1              output valid (registered)
//  iReady_BM   in   1              output ready
//  oData_BM    out  WIDTH1+WIDTH0  output data {data1, data0} (registered)
// BEHAVIOUR
//  - Reset (sync, iRST=1 at edge): buffer counts=0, oValid_BM=0, oData_BM=0,
//    oReady_AM0/1=0. oReady_AMk=1 in the first cycle after iRST deasserts.
//    Inputs are ignored while iRST=1. Reset mid-operation discards all held words.
//  - DEPTH = 2 if BURST=="yes", else 1. Per input k: FIFO buffer, count 0..DEPTH.
//    push_k = iValid_AMk && oReady_AMk. oReady_AMk <= (count_k_next < DEPTH).
//    Never push when full. iValid without ready leaves the word at the source.
//  - Output register is free when !oValid_BM || iReady_BM.
//    join = count0!=0 && count1!=0 && output register free.
//    On join: oData_BM <= {head1, head0}. oValid_BM <= 1. Pop both heads in the same edge.
//    Otherwise, if iReady_BM: oValid_BM <= 0. oData_BM holds its value.
//  - Push and pop on the same buffer in one edge: count unchanged, FIFO order kept.
//  - Words pair strictly in order: the n-th word of AM0 with the n-th word of AM1.
//    There is no loss and no duplication.
//  - Latency: both words accepted at edge t -> oValid_BM=1 in the cycle after edge t+1 (2 cycles).
//    A skewed word waits in its buffer. Latency counts from the later acceptance.
//  - BURST="yes": sustained 1 output/cycle with iReady_BM=1. With the output stalled,
//    buffers fill to 2 and oReady drops the cycle after the 2nd fill.
//  - BURST!="yes": oReady_AMk is low the cycle after a push. Max throughput 1 word/2 cycles.
//  - oValid_BM/oData_BM stay stable while oValid_BM && !iReady_BM.
// TESTING
//  1 Reset: iRST=1 for 3 cycles, iValid_AM0/1=1 -> oValid_BM=0, oData_BM=0,
//    oReady=0. Readys=1 the first cycle after release. No output from inputs driven during reset.
//  2 Aligned stream, BURST="yes": 8 pairs (0x100+i, 0x200+i) on consecutive
//    cycles, iReady_BM=1 -> oData_BM={0x200+i,0x100+i}, 8 back-to-back valid
//    cycles starting 2 cycles after the first accept.
//  3 Skew: AM0 sends 0x5 at cycle 0, AM1 sends 0x9 at cycle 4 -> oValid_BM=1
//    first at cycle 6 with {0x9,0x5}. oReady_AM0 stays 1 throughout.
//  4 Backpressure: iReady_BM=0 for 5 cycles mid-stream -> oData_BM stable.
//    oReady_AM0/1=0 once both buffers hold 2. After release, output resumes in order, no gaps or repeats.
//  5 BURST="no", both iValid held 1 -> oReady_AMk alternates 1/0, one output every 2 cycles, in order.
//  6 Reset mid-op: iRST with both buffers full and oValid_BM=1 -> next cycle
//    oValid_BM=0. After release, the first output is the first pair sent after reset.

Source files
------------

// File: rtl/combiner_if.sv
// Valid/ready stream bundle used for both combiner inputs and its output.
interface combiner_if #(
   parameter int unsigned WIDTH = 32
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/combiner.sv
// Joins two valid/ready streams into one {data1, data0} stream. Each input has
// its own small FIFO, so skew between the inputs is absorbed.
module combiner #(
   parameter int unsigned WIDTH0 = 32,
   parameter int unsigned WIDTH1 = 32,
   parameter string       BURST  = "yes"
) (
   input logic        iCLK,
   input logic        iRST,
   combiner_if.slave  am0,
   combiner_if.slave  am1,
   combiner_if.master bm
);
   localparam int unsigned DEPTH   = (BURST == "yes") ? 2 : 1;
   localparam logic [1:0]  DEPTH_C = 2'(DEPTH);

   logic [WIDTH0-1:0]        buf0_q [DEPTH];
   logic [WIDTH0-1:0]        buf0_d [DEPTH];
   logic [WIDTH1-1:0]        buf1_q [DEPTH];
   logic [WIDTH1-1:0]        buf1_d [DEPTH];
   logic [1:0]               cnt0_q, cnt0_d;
   logic [1:0]               cnt1_q, cnt1_d;
   logic                     rdy0_q, rdy0_d;
   logic                     rdy1_q, rdy1_d;
   logic                     valid_q, valid_d;
   logic [WIDTH1+WIDTH0-1:0] data_q, data_d;
   logic                     push0, push1;
   logic                     pair_fire;

   assign am0.ready = rdy0_q;
   assign am1.ready = rdy1_q;
   assign bm.valid  = valid_q;
   assign bm.data   = data_q;

   always_comb begin
      push0     = am0.valid && rdy0_q;
      push1     = am1.valid && rdy1_q;
      pair_fire = (cnt0_q != 2'd0) && (cnt1_q != 2'd0) && (!valid_q || bm.ready);
   end

   // Pop shifts the buffer toward the head first; a same-edge push then lands
   // at the post-pop count, which keeps FIFO order.
   always_comb begin
      buf0_d = buf0_q;
      cnt0_d = cnt0_q;
      if (pair_fire) begin
         for (int unsigned i = 0; i + 1 < DEPTH; i++) buf0_d[i] = buf0_q[i + 1];
         cnt0_d = cnt0_q - 2'd1;
      end
      if (push0) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            if (2'(i) == cnt0_d) buf0_d[i] = am0.data;
         cnt0_d = cnt0_d + 2'd1;
      end
      rdy0_d = cnt0_d < DEPTH_C;
   end

   always_comb begin
      buf1_d = buf1_q;
      cnt1_d = cnt1_q;
      if (pair_fire) begin
         for (int unsigned i = 0; i + 1 < DEPTH; i++) buf1_d[i] = buf1_q[i + 1];
         cnt1_d = cnt1_q - 2'd1;
      end
      if (push1) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            if (2'(i) == cnt1_d) buf1_d[i] = am1.data;
         cnt1_d = cnt1_d + 2'd1;
      end
      rdy1_d = cnt1_d < DEPTH_C;
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (pair_fire) begin
         valid_d = 1'b1;
         data_d  = {buf1_q[0], buf0_q[0]};
      end else if (bm.ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         cnt0_q  <= '0;
         cnt1_q  <= '0;
         rdy0_q  <= 1'b0;
         rdy1_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
         rdy0_q  <= rdy0_d;
         rdy1_q  <= rdy1_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   // Storage needs no reset: the counts mark which entries are meaningful.
   always_ff @(posedge iCLK) begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
   end
endmodule
